// File: rtl/aes_gcm_instance_sequencer.sv
// aes_gcm_instance_sequencer: issues INIT, AAD, TEXT and LEN beats for one GCM instance into a never-stalling pipeline.
module aes_gcm_instance_sequencer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic [0:127]     i_j0,
   input  logic [CNT_W-1:0] i_aad_blocks,
   input  logic [CNT_W-1:0] i_pt_blocks,
   input  logic             i_blk_valid,
   input  logic [0:127]     i_blk_data,
   output logic             o_blk_ready,
   output logic             o_issue,
   output logic [0:2]       o_phase,
   output logic             o_new_instance,
   output logic [0:127]     o_block,
   output logic [0:127]     o_j0,
   output logic [0:127]     o_encrypted_cb,
   output logic [0:127]     o_instance_size,
   output logic             o_busy,
   output logic             o_done
);
   typedef enum logic [1:0] {IDLE, AAD, TEXT, LEN} state_t;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] aad_left_q, aad_left_d, pt_left_q, pt_left_d;
   logic [0:127]     next_cb_q, next_cb_d, block_q, block_d, j0_q, j0_d, cb_q, cb_d, size_q, size_d;
   logic             issue_q, issue_d, new_q, new_d, done_q, done_d, hs;
   logic [0:2]       phase_q, phase_d;
   function automatic logic [0:127] inc32(input logic [0:127] x);
      return {x[0:95], x[96:127] + 32'd1};
   endfunction
   assign o_blk_ready     = (state_q == AAD) || (state_q == TEXT);
   assign o_busy          = state_q != IDLE;
   assign hs              = i_blk_valid && o_blk_ready;
   assign o_issue         = issue_q;
   assign o_phase         = phase_q;
   assign o_new_instance  = new_q;
   assign o_block         = block_q;
   assign o_j0            = j0_q;
   assign o_encrypted_cb  = cb_q;
   assign o_instance_size = size_q;
   assign o_done          = done_q;
   always_comb begin
      state_d    = state_q;
      aad_left_d = aad_left_q;
      pt_left_d  = pt_left_q;
      next_cb_d  = next_cb_q;
      block_d    = block_q;
      j0_d       = j0_q;
      cb_d       = cb_q;
      size_d     = size_q;
      issue_d    = 1'b0;
      phase_d    = 3'd0;
      new_d      = 1'b0;
      done_d     = 1'b0;
      case (state_q)
         IDLE: if (i_start) begin
            issue_d    = 1'b1;
            phase_d    = 3'd1;
            new_d      = 1'b1;
            block_d    = '0;
            j0_d       = i_j0;
            cb_d       = i_j0;
            size_d     = {{(57-CNT_W){1'b0}}, i_aad_blocks, 7'd0, {(57-CNT_W){1'b0}}, i_pt_blocks, 7'd0};
            next_cb_d  = inc32(i_j0);
            aad_left_d = i_aad_blocks;
            pt_left_d  = i_pt_blocks;
            state_d    = (i_aad_blocks != '0) ? AAD : (i_pt_blocks != '0) ? TEXT : LEN;
         end
         AAD: if (hs) begin
            issue_d    = 1'b1;
            phase_d    = 3'd2;
            block_d    = i_blk_data;
            aad_left_d = aad_left_q - CNT_W'(1);
            if (aad_left_q == CNT_W'(1)) state_d = (pt_left_q != '0) ? TEXT : LEN;
         end
         TEXT: if (hs) begin
            issue_d   = 1'b1;
            phase_d   = 3'd3;
            block_d   = i_blk_data;
            cb_d      = next_cb_q;
            next_cb_d = inc32(next_cb_q);
            pt_left_d = pt_left_q - CNT_W'(1);
            if (pt_left_q == CNT_W'(1)) state_d = LEN;
         end
         LEN: begin
            issue_d = 1'b1;
            phase_d = 3'd4;
            block_d = size_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         aad_left_q <= '0;
         pt_left_q  <= '0;
         next_cb_q  <= '0;
         block_q    <= '0;
         j0_q       <= '0;
         cb_q       <= '0;
         size_q     <= '0;
         issue_q    <= 1'b0;
         phase_q    <= 3'd0;
         new_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         aad_left_q <= aad_left_d;
         pt_left_q  <= pt_left_d;
         next_cb_q  <= next_cb_d;
         block_q    <= block_d;
         j0_q       <= j0_d;
         cb_q       <= cb_d;
         size_q     <= size_d;
         issue_q    <= issue_d;
         phase_q    <= phase_d;
         new_q      <= new_d;
         done_q     <= done_d;
      end
   end
endmodule

// File: tb/tb_aes_gcm_instance_sequencer.sv
// tb_aes_gcm_instance_sequencer: scoreboard bench; stimulus queues cycle-stamped beats, a monitor pops and compares them.
module tb_aes_gcm_instance_sequencer;
   localparam int CNT_W = 16;
   typedef struct {
      int           stamp;
      logic [0:2]   phase;
      logic         newi;
      logic         done;
      logic [0:127] blk;
      logic [0:127] cb;
      logic [0:127] j0;
      logic [0:127] size;
   } beat_t;
   logic             clk = 1'b0, rst_n = 1'b1, i_start = 1'b0, i_blk_valid = 1'b0;
   logic [0:127]     i_j0 = '0, i_blk_data = '0;
   logic [CNT_W-1:0] i_aad_blocks = '0, i_pt_blocks = '0;
   logic             o_blk_ready, o_issue, o_new_instance, o_busy, o_done;
   logic [0:2]       o_phase;
   logic [0:127]     o_block, o_j0, o_encrypted_cb, o_instance_size;
   int               cyc = 0, n_chk = 0, n_fail = 0;
   beat_t            sb[$];
   aes_gcm_instance_sequencer #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_j0(i_j0),
      .i_aad_blocks(i_aad_blocks), .i_pt_blocks(i_pt_blocks),
      .i_blk_valid(i_blk_valid), .i_blk_data(i_blk_data), .o_blk_ready(o_blk_ready),
      .o_issue(o_issue), .o_phase(o_phase), .o_new_instance(o_new_instance),
      .o_block(o_block), .o_j0(o_j0), .o_encrypted_cb(o_encrypted_cb),
      .o_instance_size(o_instance_size), .o_busy(o_busy), .o_done(o_done)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected end of test");
      $fatal(1);
   end
   function automatic logic [0:127] inc32(input logic [0:127] x);
      logic [0:31] lo;
      lo = x[96:127] + 32'd1;
      return {x[0:95], lo};
   endfunction
   function automatic logic [0:127] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic idle(input int n);
      i_blk_valid = 1'b0;
      repeat (n) tick();
   endtask
   task automatic chk(input string nm, input logic [0:127] act, input logic [0:127] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask
   task automatic expect_beat(input logic [0:2] ph, input logic nw, input logic dn,
                              input logic [0:127] blk, input logic [0:127] cb,
                              input logic [0:127] j0, input logic [0:127] sz);
      beat_t b;
      b.stamp = cyc + 1;
      b.phase = ph;
      b.newi  = nw;
      b.done  = dn;
      b.blk   = blk;
      b.cb    = cb;
      b.j0    = j0;
      b.size  = sz;
      sb.push_back(b);
   endtask
   task automatic run(input logic [0:127] j0, input int na, input int np, input bit bub, input int mid_start);
      logic [0:127] cb, ncb, sz;
      logic [0:63]  la, lc;
      la = 64'(na * 128);
      lc = 64'(np * 128);
      sz = {la, lc};
      i_j0         = j0;
      i_aad_blocks = CNT_W'(na);
      i_pt_blocks  = CNT_W'(np);
      i_start      = 1'b1;
      expect_beat(3'd1, 1'b1, 1'b0, '0, j0, j0, sz);
      tick();
      i_start      = 1'b0;
      i_j0         = rnd128();
      i_aad_blocks = CNT_W'($urandom_range(1, 9));
      i_pt_blocks  = CNT_W'($urandom_range(1, 9));
      chk("ready_after_start", 128'(o_blk_ready), 128'((na + np) != 0));
      cb  = j0;
      ncb = inc32(j0);
      for (int k = 0; k < na + np; k++) begin
         i_blk_valid = 1'b1;
         i_blk_data  = rnd128();
         i_start     = (k == mid_start);
         if (k < na) expect_beat(3'd2, 1'b0, 1'b0, i_blk_data, cb, j0, sz);
         else begin
            cb  = ncb;
            ncb = inc32(ncb);
            expect_beat(3'd3, 1'b0, 1'b0, i_blk_data, cb, j0, sz);
         end
         tick();
         i_start = 1'b0;
         if (bub && k < na + np - 1) begin
            i_blk_valid = 1'b0;
            i_blk_data  = rnd128();
            tick();
         end
      end
      i_blk_valid = 1'b0;
      expect_beat(3'd4, 1'b0, 1'b1, sz, cb, j0, sz);
      tick();
      chk("busy_in_done_cycle", 128'(o_busy), '0);
   endtask
   initial begin
      fork
         forever begin
            @(negedge clk);
            if (o_issue) begin
               if (sb.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_beat: phase %0d at cycle %0d, expected no beat", o_phase, cyc);
               end else begin
                  beat_t b;
                  b = sb.pop_front();
                  chk("beat_cycle", 128'(cyc), 128'(b.stamp));
                  chk("beat_phase", 128'(o_phase), 128'(b.phase));
                  chk("beat_new_instance", 128'(o_new_instance), 128'(b.newi));
                  chk("beat_done", 128'(o_done), 128'(b.done));
                  chk("beat_block", o_block, b.blk);
                  chk("beat_cb", o_encrypted_cb, b.cb);
                  chk("beat_j0", o_j0, b.j0);
                  chk("beat_size", o_instance_size, b.size);
               end
            end else chk("bubble_phase_new_done", 128'({o_phase, o_new_instance, o_done}), '0);
         end
      join_none
      #1 rst_n = 1'b0;
      #12;
      chk("rst_ctrl", 128'({o_issue, o_phase, o_new_instance, o_done, o_busy, o_blk_ready}), '0);
      chk("rst_block", o_block, '0);
      chk("rst_cb", o_encrypted_cb, '0);
      chk("rst_j0", o_j0, '0);
      chk("rst_size", o_instance_size, '0);
      rst_n = 1'b1;
      tick();
      run(128'h1, 2, 3, 1'b0, -1);
      idle(2);
      run(128'h0123_4567_89ab_cdef_0011_2233_0000_0010, 0, 1, 1'b0, -1);
      run(128'hdead_beef_0000_0000_1111_2222_3333_4444, 0, 0, 1'b0, -1);
      idle(2);
      run(128'h5555_6666_7777_8888_9999_aaaa_0000_0100, 0, 2, 1'b1, -1);
      idle(1);
      run(128'ha5a5_a5a5_5a5a_5a5a_c3c3_c3c3_ffff_fffe, 0, 2, 1'b0, -1);
      idle(1);
      run(128'h1234_0000_0000_0000_0000_0000_0000_0007, 3, 1, 1'b0, 1);
      run(128'hfeed_0000_0000_0000_0000_0000_0000_0100, 1, 1, 1'b0, -1);
      idle(2);
      i_j0         = 128'h0bad_0000_0000_0000_0000_0000_0000_0020;
      i_aad_blocks = '0;
      i_pt_blocks  = CNT_W'(4);
      i_start      = 1'b1;
      expect_beat(3'd1, 1'b1, 1'b0, '0, i_j0, i_j0, {64'd0, 64'd512});
      tick();
      i_start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         i_blk_valid = 1'b1;
         i_blk_data  = rnd128();
         expect_beat(3'd3, 1'b0, 1'b0, i_blk_data, 128'h0bad_0000_0000_0000_0000_0000_0000_0021 + 128'(k),
                     128'h0bad_0000_0000_0000_0000_0000_0000_0020, {64'd0, 64'd512});
         tick();
      end
      i_blk_valid = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_ctrl", 128'({o_issue, o_phase, o_new_instance, o_done, o_busy, o_blk_ready}), '0);
      chk("midrst_block", o_block, '0);
      chk("midrst_cb", o_encrypted_cb, '0);
      chk("midrst_j0", o_j0, '0);
      chk("midrst_size", o_instance_size, '0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      tick();
      idle(4);
      chk("midrst_no_pending", 128'(sb.size()), '0);
      run(128'h7777_0000_0000_0000_0000_0000_0000_0001, 1, 1, 1'b0, -1);
      idle(3);
      chk("scoreboard_empty", 128'(sb.size()), '0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
